// File: rtl/apb_pkg.sv
// apb_pkg: shared state type and default widths for the APB round-robin arbiter.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_AW_DEF = 32;
  localparam int unsigned APB_DW_DEF = 32;

endpackage

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: combinational round-robin picker. Search starts at i_ptr and wraps modulo
// NREQ; requesters set in i_mask are not eligible.
module apb_rr_pick
  import apb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  input  logic [NREQ-1:0] i_mask,
  output logic [NREQ-1:0] o_win,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  logic [NREQ-1:0]   w_elig;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [PW:0]       w_sum;

  assign w_elig = i_req & ~i_mask;
  // Rotate so that bit j of w_rot is requester (ptr + j) mod NREQ.
  assign w_dbl  = {w_elig, w_elig} >> i_ptr;
  assign w_rot  = w_dbl[NREQ-1:0];

  // Find the smallest rotated offset with a request; scanning downward lets it overwrite.
  always_comb begin
    o_any = 1'b0;
    w_sum = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_any = 1'b1;
        w_sum = {1'b0, i_ptr} + (PW+1)'(j);
      end
    end
    if (w_sum >= (PW+1)'(NREQ)) begin
      w_sum = w_sum - (PW+1)'(NREQ);
    end
  end

  assign o_idx = w_sum[PW-1:0];

  // Expand the winning index to a one-hot vector.
  always_comb begin
    o_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      o_win[i] = o_any && (o_idx == PW'(i));
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: shares one APB master port among NREQ requesters, round-robin.
// Optional build macro APB_TIMEOUT_EN: ACCESS is force-terminated with an error after
// TIMEOUT cycles without pready. Without it, ACCESS waits indefinitely.
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = APB_AW_DEF,
  parameter int unsigned DW      = APB_DW_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               pselx,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  apb_state_e      r_state;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt, r_done;
  logic [DW-1:0]   r_rsp_rdata, r_pwdata;
  logic [AW-1:0]   r_paddr;
  logic            r_rsp_err, r_pselx, r_penable, r_pwrite;

  logic [NREQ-1:0] w_mask, w_win;
  logic [PW-1:0]   w_idx, w_ptr_nxt;
  logic            w_any, w_sel_write;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  // The owner's own request is masked at its completion edge so others get a turn.
  assign w_mask = (r_state == ACCESS) ? r_gnt : '0;

  apb_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .i_mask (w_mask),
    .o_win  (w_win),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  // Select the winning requester's command for latching at the grant edge.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_sel_write = req_write[i];
        w_sel_addr  = req_addr[i*AW +: AW];
        w_sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Transfer sequencer: state, latched command and all registered outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_pselx     <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
`ifdef APB_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          r_pselx   <= 1'b0;
          r_penable <= 1'b0;
          r_gnt     <= '0;
          if (w_any) begin
            r_state   <= SETUP;
            r_pselx   <= 1'b1;
            r_gnt     <= w_win;
            r_ptr     <= w_ptr_nxt;
            r_pwrite  <= w_sel_write;
            r_paddr   <= w_sel_addr;
            r_pwdata  <= w_sel_wdata;
            r_rsp_err <= 1'b0;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
          // After a back-to-back grant the previous error stays visible for its done cycle only.
          r_rsp_err <= 1'b0;
`ifdef APB_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_rsp_err   <= pslverr;
            r_done      <= r_gnt;
            r_penable   <= 1'b0;
            if (w_any) begin
              r_state  <= SETUP;
              r_gnt    <= w_win;
              r_ptr    <= w_ptr_nxt;
              r_pwrite <= w_sel_write;
              r_paddr  <= w_sel_addr;
              r_pwdata <= w_sel_wdata;
            end else begin
              r_state <= IDLE;
              r_pselx <= 1'b0;
              r_gnt   <= '0;
            end
          end
`ifdef APB_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_done      <= r_gnt;
            r_state     <= IDLE;
            r_pselx     <= 1'b0;
            r_penable   <= 1'b0;
            r_gnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state   <= IDLE;
          r_gnt     <= '0;
          r_rsp_err <= 1'b0;
          r_pselx   <= 1'b0;
          r_penable <= 1'b0;
          r_pwrite  <= 1'b0;
          r_paddr   <= '0;
          r_pwdata  <= '0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign pselx     = r_pselx;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: directed scenarios plus random traffic against a transfer-level model
// of the arbiter; responses are queued by the model and checked when done is presented.
module tb_apb_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic               pclk = 1'b0;
  logic               presetn = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    req_write = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    gnt, done;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err, pselx, penable, pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata = '0;
  logic               pready = 1'b0;
  logic               pslverr = 1'b0;

  apb_rr_arbiter #(
    .NREQ    (NREQ),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NREQ-1:0] done;
    logic [DW-1:0]   rdata;
    logic            err;
  } rsp_t;
  rsp_t sb_q[$];

  // Transfer-level model: which requester owns the bus, in which phase, with what command.
  typedef enum {MFree, MSetup, MAccess} mphase_e;
  mphase_e       m_phase;
  int            m_ptr, m_owner, m_acc;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_phase = MFree;
    m_ptr   = 0;
    m_owner = 0;
    m_acc   = 0;
    sb_q.delete();
  endtask

  task automatic m_grant(input int w);
    m_owner = w;
    m_ptr   = (w + 1) % NREQ;
    m_write = req_write[w];
    m_addr  = req_addr[w*AW +: AW];
    m_wdata = req_wdata[w*DW +: DW];
    m_phase = MSetup;
  endtask

  task automatic m_step();
    logic [NREQ-1:0] r;
    int w;
    r = req;
    case (m_phase)
      MFree: begin
        w = rr_pick(r, m_ptr);
        if (w >= 0) m_grant(w);
      end
      MSetup: begin
        m_phase = MAccess;
        m_acc   = 0;
      end
      default: begin
        if (pready) begin
          sb_q.push_back('{done: NREQ'(1) << m_owner,
                           rdata: (m_write ? DW'(0) : prdata), err: pslverr});
          r[m_owner] = 1'b0;
          w = rr_pick(r, m_ptr);
          if (w >= 0) m_grant(w);
          else m_phase = MFree;
        end else begin
          m_acc++;
`ifdef APB_TIMEOUT_EN
          if (m_acc == TIMEOUT) begin
            sb_q.push_back('{done: NREQ'(1) << m_owner, rdata: DW'(0), err: 1'b1});
            m_phase = MFree;
          end
`endif
        end
      end
    endcase
  endtask

  // Model advances on every clock edge and resets asynchronously with the DUT.
  initial begin
    m_reset();
    forever begin
      @(posedge pclk or negedge presetn);
      if (!presetn) m_reset();
      else m_step();
    end
  end

  // Monitor: compares bus/grant against the model and pops responses when done appears.
  initial begin
    logic            exp_psel, exp_pen;
    logic [NREQ-1:0] exp_gnt;
    rsp_t            e;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        checks++;
        if (pselx || penable || pwrite || gnt != 0 || done != 0 || rsp_err ||
            paddr != 0 || pwdata != 0 || rsp_rdata != 0) begin
          errors++;
          $display("FAIL reset_outputs: psel=%0b pen=%0b gnt=%b done=%b err=%0b, expected all 0",
                   pselx, penable, gnt, done, rsp_err);
        end
      end else begin
        exp_psel = (m_phase != MFree);
        exp_pen  = (m_phase == MAccess);
        exp_gnt  = (m_phase == MFree) ? '0 : NREQ'(1) << m_owner;
        checks++;
        if (pselx !== exp_psel || penable !== exp_pen || gnt !== exp_gnt) begin
          errors++;
          $display("FAIL bus_phase: got psel=%0b pen=%0b gnt=%b, expected psel=%0b pen=%0b gnt=%b",
                   pselx, penable, gnt, exp_psel, exp_pen, exp_gnt);
        end
        if (m_phase != MFree) begin
          checks++;
          if (paddr !== m_addr || pwrite !== m_write || pwdata !== m_wdata) begin
            errors++;
            $display("FAIL bus_cmd: got a=%h w=%0b d=%h, expected a=%h w=%0b d=%h",
                     paddr, pwrite, pwdata, m_addr, m_write, m_wdata);
          end
        end
        if (m_phase == MAccess) begin
          checks++;
          if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rsp_err_cleared: got %0b during ACCESS, expected 0", rsp_err);
          end
        end
        if (done != 0 || sb_q.size() != 0) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL response: got unexpected done=%b, expected none", done);
          end else begin
            e = sb_q.pop_front();
            if (done !== e.done || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
              errors++;
              $display("FAIL response: got done=%b rd=%h err=%0b, expected done=%b rd=%h err=%0b",
                       done, rsp_rdata, rsp_err, e.done, e.rdata, e.err);
            end
          end
        end
      end
    end
  end

  // Advance one clock; a requester drops req in its done cycle.
  task automatic step();
    @(posedge pclk);
    #1;
    req = req & ~done;
  endtask

  task automatic do_reset();
    req = '0;
    presetn = 1'b0;
    step();
    step();
    presetn = 1'b1;
  endtask

  task automatic wait_done(input int idx, input int max_cyc, output int n);
    n = 0;
    while (done[idx] !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    if (done[idx] !== 1'b1) chk("wait_done_bound", 64'(n), 64'(max_cyc + 1));
  endtask

  task automatic drain();
    pready = 1'b1;
    for (int c = 0; c < 200 && (req != 0 || pselx); c++) step();
    chk("drain_idle", {63'd0, pselx}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, ngr, gap, w;
    int order[8];

    // Reset state.
    #3;
    chk("reset_psel", {63'd0, pselx}, 64'd0);
    chk("reset_gnt", 64'(gnt), 64'd0);
    @(posedge pclk);
    #1;
    presetn = 1'b1;
    step();

    // 1: single write, pready tied high, 3 cycles req -> done.
    pready = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2*AW +: AW] = 32'h10;
    req_wdata[2*DW +: DW] = 32'hA5A5_0001;
    req[2] = 1'b1;
    wait_done(2, 10, n);
    chk("t1_latency", 64'(n), 64'd3);
    chk("t1_err", {63'd0, rsp_err}, 64'd0);
    drain();

    // 2: read with three wait states.
    pready = 1'b0;
    req_write[0] = 1'b0;
    req_addr[0*AW +: AW] = 32'h40;
    req[0] = 1'b1;
    for (int c = 0; c < 10 && !penable; c++) step();
    acc = penable ? 1 : 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (penable) acc++;
    end
    pready = 1'b1;
    prdata = 32'hDEAD_BEEF;
    wait_done(0, 5, n);
    chk("t2_access_cycles", 64'(acc), 64'd4);
    chk("t2_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    drain();

    // 3: all requesters held, grants must cycle 0,1,2,3,0 with no idle.
    do_reset();
    step();
    pslverr = 1'b0;
    pready  = 1'b1;
    req = '1;
    ngr = 0;
    gap = 0;
    for (int c = 0; c < 40 && ngr < 5; c++) begin
      step();
      req = ~done;
      if (pselx && !penable) begin
        order[ngr] = oh2i(gnt);
        ngr++;
      end
      if (ngr > 0 && !pselx) gap++;
    end
    for (int k = 0; k < 5; k++) chk($sformatf("t3_order%0d", k), 64'(order[k]), 64'(k % NREQ));
    chk("t3_no_idle", 64'(gap), 64'd0);
    drain();

    // 4: slave error, then the next grant clears rsp_err.
    req_write[1] = 1'b1;
    pslverr = 1'b1;
    req[1] = 1'b1;
    wait_done(1, 10, n);
    chk("t4_err", {63'd0, rsp_err}, 64'd1);
    pslverr = 1'b0;
    step();
    req[1] = 1'b1;
    for (int c = 0; c < 10 && !pselx; c++) step();
    chk("t4_err_cleared", {63'd0, rsp_err}, 64'd0);
    wait_done(1, 10, n);
    drain();

    // 5: reset in the middle of ACCESS; pointer must restart at 0.
    pready = 1'b0;
    req_write[0] = 1'b0;
    req[0] = 1'b1;
    for (int c = 0; c < 10 && !penable; c++) step();
    #2;
    presetn = 1'b0;
    req = '0;
    #1;
    chk("t5_async_psel", {62'd0, pselx, penable}, 64'd0);
    chk("t5_async_gnt", 64'({gnt, done}), 64'd0);
    @(posedge pclk);
    @(posedge pclk);
    #1;
    presetn = 1'b1;
    step();
    pready = 1'b1;
    req[3] = 1'b1;
    req[0] = 1'b1;
    ngr = 0;
    for (int c = 0; c < 20 && ngr < 2; c++) begin
      step();
      if (pselx && !penable) begin
        order[ngr] = oh2i(gnt);
        ngr++;
      end
    end
    chk("t5_first_grant", 64'(order[0]), 64'd0);
    chk("t5_second_grant", 64'(order[1]), 64'd3);
    drain();

    // Random traffic with random wait states, errors and changing command inputs.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        req_write[i] = 1'($urandom_range(0, 1));
        req_addr[i*AW +: AW] = $urandom;
        req_wdata[i*DW +: DW] = $urandom;
        if (!req[i] && !done[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
      pready  = ($urandom_range(0, 2) != 0);
      prdata  = $urandom;
      pslverr = ($urandom_range(0, 4) == 0);
    end
    pslverr = 1'b0;
    drain();

`ifdef APB_TIMEOUT_EN
    // 6: pready stuck low terminates after TIMEOUT ACCESS cycles.
    step();
    pready = 1'b0;
    prdata = 32'h1234_5678;
    req_write[1] = 1'b0;
    req[1] = 1'b1;
    for (int c = 0; c < 10 && !penable; c++) step();
    acc = penable ? 1 : 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done[1]) break;
      if (penable) acc++;
    end
    chk("t6_access_cycles", 64'(acc), 64'(TIMEOUT));
    chk("t6_err", {63'd0, rsp_err}, 64'd1);
    chk("t6_rdata", 64'(rsp_rdata), 64'd0);
    chk("t6_idle", {62'd0, pselx, penable}, 64'd0);
    drain();
`endif

    step();
    step();
    w = sb_q.size();
    chk("sb_empty", 64'(w), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Shares one APB master port among NREQ requesters using round-robin arbitration.
- Sequences every transfer through IDLE/SETUP/ACCESS and drives pselx, penable, paddr, pwrite and pwdata from a latched command.
- Returns prdata and the error flag to the winning requester with a one-cycle done pulse.
- Sits between on-chip command sources (DMA, CPU shim, config engine) and the APB peripheral fabric.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, ACCESS cycles without pready before forced termination (used only with APB_TIMEOUT_EN).

Ports:
- pclk  input  1  APB clock; all logic on the rising edge.
- presetn  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester transfer request; held high until that requester's done.
- req_write  input  NREQ  per-requester direction, 1 = write.
- req_addr  input  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
- req_wdata  input  NREQ*DW  packed write data.
- gnt  output  NREQ  one-hot; current owner during SETUP/ACCESS.
- done  output  NREQ  one-cycle completion pulse to the owner.
- rsp_rdata  output  DW  captured prdata; valid when any done bit is high.
- rsp_err  output  1  captured pslverr (or timeout); valid with done.
- pselx  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  AW  APB address.
- pwdata  output  DW  APB write data.
- prdata  input  DW  APB read data.
- pready  input  1  APB ready.
- pslverr  input  1  APB slave error.

Behaviour:
- Reset (async, presetn=0): state=IDLE. pselx, penable, pwrite, paddr, pwdata, gnt, done, rsp_rdata and rsp_err all 0. RR pointer=0, so req[0] has highest priority first. A transfer in flight is abandoned: pselx drops immediately and no done is issued.
- All APB outputs, gnt, done and rsp_* are registered.
- Arbitration: search starts at the pointer and wraps modulo NREQ; the first set req wins. On grant, the pointer becomes winner+1 (mod NREQ).
- IDLE: pselx=0, penable=0. If any req is set, latch the winner's write/addr/wdata, set gnt[winner], and go to SETUP next edge. Latency from req rising to pselx is 1 cycle.
- SETUP: pselx=1, penable=0 for exactly one cycle, then ACCESS.
- ACCESS: pselx=1, penable=1; paddr, pwrite and pwdata are held stable.
  - pready=0: remain in ACCESS.
  - pready=1 at an edge: capture prdata into rsp_rdata (0 for writes) and pslverr into rsp_err, and pulse done[owner] in the following cycle.
- Back-to-back: at the completion edge, re-arbitrate with req[owner] masked.
  - Another request pending: go directly to SETUP with the new command, latched that edge. No IDLE cycle; pselx stays 1 and penable drops to 0.
  - None pending: go to IDLE; gnt=0.
- The requester must drop req in the done cycle. A req still high after done is treated as a new request.
- rsp_err is meaningful only for the transfer completing; it is cleared to 0 on the next grant.
- Request inputs changing while not granted are ignored. Command inputs are sampled only at the grant edge.
- All requesters asserting continuously: grants cycle 0,1,2,3,0,…; no requester waits more than NREQ-1 transfers.
- Invalid state encoding: next state is IDLE, outputs are 0.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An ACCESS cycle counter is cleared on entry to ACCESS.
  - When it reaches TIMEOUT with pready still 0, the transfer terminates: done[owner]=1, rsp_err=1, rsp_rdata=0.
  - Next state is IDLE (no back-to-back after a timeout). pselx and penable drop on that edge.
  - pready arriving on the same edge as the limit counts as normal completion.
- Undefined: there is no counter, ACCESS waits indefinitely, and TIMEOUT is unused.

Decomposition:
- Package apb_pkg:
  - typedef enum logic [1:0] apb_state_e {IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2}.
  - Default AW/DW localparams.
- Sub-module apb_rr_pick: purely combinational.
  - Inputs: req vector, pointer, mask.
  - Outputs: one-hot winner, winner index, any-valid flag.
  - Instantiated once.

Test Plan:
1. Single write: req[2]=1, addr=0x10, wdata=0xA5A5_0001, pready tied 1 → pselx high 1 cycle after req, penable on the next cycle, done[2] pulse, rsp_err=0, 3 cycles req→done.
2. Read with wait states: req[0] read, addr=0x40; pready low 3 ACCESS cycles, then high with prdata=0xDEAD_BEEF → ACCESS lasts 4 cycles, rsp_rdata=0xDEAD_BEEF, paddr stable throughout.
3. Round-robin fairness: all four req held after reset, pready=1 → grant order 0,1,2,3,0; no IDLE between transfers; penable low exactly one cycle between transfers.
4. Error: pslverr=1 with pready on req[1] write → done[1] with rsp_err=1; the next grant clears rsp_err.
5. Reset mid-ACCESS: presetn low while pready=0 → pselx, penable and gnt go to 0 asynchronously with no done. After release with req[3]=1 → grant goes to 3 and pointer restarts from 0.
6. APB_TIMEOUT_EN with TIMEOUT=16, pready stuck 0 → done after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, state returns to IDLE.
